// File: rtl/expect_pkg.sv
// rtl/expect_pkg.sv - shared types and default widths for the expected-pattern sequencer
package expect_pkg;
    localparam int STEP_W    = 4;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 16;
    localparam int NUM_STEPS = 16;

    localparam int DISP = 0;
    localparam int CHK  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;
endpackage

// File: rtl/expect_sched_if.sv
// rtl/expect_sched_if.sv - requester and ROM port bundle for expect_sched
interface expect_sched_if #(
    parameter int ADDR_W = expect_pkg::ADDR_W,
    parameter int DATA_W = expect_pkg::DATA_W,
    parameter int STEP_W = expect_pkg::STEP_W
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_x;
    logic [ADDR_W-1:0] disp_y;
    logic              disp_gnt;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;
    logic              chk_req;
    logic [ADDR_W-1:0] chk_x;
    logic [ADDR_W-1:0] chk_y;
    logic              chk_gnt;
    logic              chk_valid;
    logic [DATA_W-1:0] chk_data;
    logic [STEP_W-1:0] rd_step;
    logic [STEP_W-1:0] mem_step;
    logic [ADDR_W-1:0] mem_x;
    logic [ADDR_W-1:0] mem_y;
    logic [DATA_W-1:0] mem_data;

    modport slave (
        input  disp_req, disp_x, disp_y, chk_req, chk_x, chk_y, mem_data,
        output disp_gnt, disp_valid, disp_data, chk_gnt, chk_valid, chk_data,
               rd_step, mem_step, mem_x, mem_y
    );

    modport master (
        output disp_req, disp_x, disp_y, chk_req, chk_x, chk_y, mem_data,
        input  disp_gnt, disp_valid, disp_data, chk_gnt, chk_valid, chk_data,
               rd_step, mem_step, mem_x, mem_y
    );
endinterface

// File: rtl/expect_arb.sv
// rtl/expect_arb.sv - display-priority ROM port arbiter with checker starvation guard
module expect_arb
    import expect_pkg::*;
#(
    parameter int ADDR_W     = expect_pkg::ADDR_W,
    parameter int STARVE_MAX = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_x,
    input  logic [ADDR_W-1:0] disp_y,
    input  logic              chk_req,
    input  logic [ADDR_W-1:0] chk_x,
    input  logic [ADDR_W-1:0] chk_y,
    output logic [1:0]        gnt,
    output logic [ADDR_W-1:0] mem_x,
    output logic [ADDR_W-1:0] mem_y
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q, starve_d;

    always_comb begin
        gnt      = 2'b00;
        gnt[CHK] = chk_req && (!disp_req || starve_q == SW'(STARVE_MAX));
        gnt[DISP] = disp_req && !gnt[CHK];

        mem_x = '0;
        mem_y = '0;
        if (gnt[CHK]) begin
            mem_x = chk_x;
            mem_y = chk_y;
        end else if (gnt[DISP]) begin
            mem_x = disp_x;
            mem_y = disp_y;
        end

        // Saturating count of consecutive denied checker cycles
        starve_d = starve_q;
        if (gnt[CHK]) begin
            starve_d = '0;
        end else if (chk_req && starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
endmodule

// File: rtl/expect_sched.sv
// rtl/expect_sched.sv - step sequencer and shared ROM read port; EXPECT_LOOP_EN makes the pattern repeat
module expect_sched
    import expect_pkg::*;
#(
    parameter int TICK_W     = 25,
    parameter int NUM_STEPS  = expect_pkg::NUM_STEPS,
    parameter int STEP_W     = expect_pkg::STEP_W,
    parameter int ADDR_W     = expect_pkg::ADDR_W,
    parameter int DATA_W     = expect_pkg::DATA_W,
    parameter int STARVE_MAX = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    expect_sched_if.slave     bus,
    output logic [STEP_W-1:0] step,
    output logic              step_pulse,
    output logic              running,
    output logic              done
);
    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_RUN   = 2'(RUN);
    localparam logic [1:0] ST_PAUSE = 2'(PAUSE);
    localparam logic [1:0] ST_DONE  = 2'(DONE);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    logic [1:0]        state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              step_pulse_q, step_pulse_d;
    logic              tick_en, tick_wrap;

    logic [1:0]        gnt;
    logic              disp_valid_q, disp_valid_d;
    logic              chk_valid_q, chk_valid_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic [DATA_W-1:0] chk_data_q, chk_data_d;
    logic [STEP_W-1:0] rd_step_q, rd_step_d;

    expect_arb #(
        .ADDR_W    (ADDR_W),
        .STARVE_MAX(STARVE_MAX)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .disp_req(bus.disp_req),
        .disp_x  (bus.disp_x),
        .disp_y  (bus.disp_y),
        .chk_req (bus.chk_req),
        .chk_x   (bus.chk_x),
        .chk_y   (bus.chk_y),
        .gnt     (gnt),
        .mem_x   (bus.mem_x),
        .mem_y   (bus.mem_y)
    );

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        step_d       = step_q;
        step_pulse_d = 1'b0;
        // The cycle pause drops already counts, so a resumed step finishes on time
        tick_en   = (state_q == ST_RUN || state_q == ST_PAUSE) && !pause;
        tick_wrap = tick_en && (tick_q == '1);

        if (start) begin
            state_d = ST_RUN;
            tick_d  = '0;
            step_d  = '0;
        end else begin
            if (state_q == ST_RUN && pause) begin
                state_d = ST_PAUSE;
            end else if (state_q == ST_PAUSE && !pause) begin
                state_d = ST_RUN;
            end
            if (tick_en) begin
                tick_d = tick_q + TICK_W'(1);
            end
            if (tick_wrap) begin
                step_pulse_d = 1'b1;
                if (step_q == LAST_STEP) begin
                    step_d = '0;
`ifndef EXPECT_LOOP_EN
                    state_d = ST_DONE;
`endif
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
        end
    end

    assign bus.mem_step = (gnt != 2'b00) ? step_q : '0;

    always_comb begin
        disp_valid_d = gnt[DISP];
        chk_valid_d  = gnt[CHK];
        disp_data_d  = gnt[DISP] ? bus.mem_data : disp_data_q;
        chk_data_d   = gnt[CHK] ? bus.mem_data : chk_data_q;
        rd_step_d    = (gnt != 2'b00) ? step_q : rd_step_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            step_q       <= '0;
            step_pulse_q <= 1'b0;
            disp_valid_q <= 1'b0;
            chk_valid_q  <= 1'b0;
            disp_data_q  <= '0;
            chk_data_q   <= '0;
            rd_step_q    <= '0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            step_q       <= step_d;
            step_pulse_q <= step_pulse_d;
            disp_valid_q <= disp_valid_d;
            chk_valid_q  <= chk_valid_d;
            disp_data_q  <= disp_data_d;
            chk_data_q   <= chk_data_d;
            rd_step_q    <= rd_step_d;
        end
    end

    assign bus.disp_gnt   = gnt[DISP];
    assign bus.chk_gnt    = gnt[CHK];
    assign bus.disp_valid = disp_valid_q;
    assign bus.chk_valid  = chk_valid_q;
    assign bus.disp_data  = disp_data_q;
    assign bus.chk_data   = chk_data_q;
    assign bus.rd_step    = rd_step_q;
    assign step           = step_q;
    assign step_pulse     = step_pulse_q;
    assign running        = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign done           = (state_q == ST_DONE);
endmodule

// File: tb/tb_expect_sched.sv
// tb/tb_expect_sched.sv - directed self-checking bench for expect_sched (TICK_W=3)
module tb_expect_sched;
    import expect_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] step;
    logic       step_pulse, running, done;
    int         n_cmp = 0;
    int         n_mis = 0;
    int         n;

    expect_sched_if bus ();

    expect_sched #(.TICK_W(3), .STARVE_MAX(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pause     (pause),
        .bus       (bus),
        .step      (step),
        .step_pulse(step_pulse),
        .running   (running),
        .done      (done)
    );

    always #5 clk = ~clk;

    // ROM stand-in: word = {step, y[5:0], x[5:0]}
    assign bus.mem_data = {bus.mem_step, bus.mem_y[5:0], bus.mem_x[5:0]};

    function automatic logic [15:0] rom_word(input logic [3:0] s, input logic [7:0] x, input logic [7:0] y);
        return {s, y[5:0], x[5:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(output int cycles);
        cycles = 0;
        do begin
            step_clk();
            cycles++;
        end while (!step_pulse && cycles < 40);
    endtask

    initial begin
        bus.disp_req = 1'b0; bus.disp_x = '0; bus.disp_y = '0;
        bus.chk_req  = 1'b0; bus.chk_x  = '0; bus.chk_y  = '0;

        #12;
        check_eq("rst_step", step, 0);
        check_eq("rst_running", running, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pulse", step_pulse, 0);
        check_eq("rst_dvalid", bus.disp_valid, 0);
        check_eq("rst_cvalid", bus.chk_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step_clk();

        // ROM readable while idle
        bus.disp_req = 1'b1; bus.disp_x = 8'd5; bus.disp_y = 8'd9;
        #1;
        check_eq("idle_dgnt", bus.disp_gnt, 1);
        check_eq("idle_cgnt", bus.chk_gnt, 0);
        check_eq("idle_memx", bus.mem_x, 5);
        check_eq("idle_memy", bus.mem_y, 9);
        step_clk();
        check_eq("idle_dvalid", bus.disp_valid, 1);
        check_eq("idle_ddata", bus.disp_data, rom_word(4'd0, 8'd5, 8'd9));
        check_eq("idle_cvalid", bus.chk_valid, 0);
        bus.disp_req = 1'b0;
        step_clk();
        check_eq("idle_dvalid_off", bus.disp_valid, 0);
        check_eq("idle_ddata_hold", bus.disp_data, rom_word(4'd0, 8'd5, 8'd9));
        check_eq("idle_memx_zero", bus.mem_x, 0);

        start = 1'b1;
        step_clk();
        start = 1'b0;
        check_eq("start_running", running, 1);
        check_eq("start_step", step, 0);
        for (int s = 1; s <= 3; s++) begin
            wait_pulse(n);
            check_eq("tick_period", n, 8);
            check_eq("tick_step", step, s);
        end

        // Pause mid-step 3 after 3 ticks: 5 ticks remain on resume
        repeat (3) step_clk();
        pause = 1'b1;
        repeat (20) step_clk();
        check_eq("pause_step", step, 3);
        check_eq("pause_running", running, 1);
        check_eq("pause_pulse", step_pulse, 0);
        pause = 1'b0;
        wait_pulse(n);
        check_eq("resume_rest", n, 5);
        check_eq("resume_step", step, 4);
        wait_pulse(n);
        check_eq("step5", step, 5);

        // Checker read in the 5->6 tick cycle
        repeat (7) step_clk();
        bus.chk_req = 1'b1; bus.chk_x = 8'd3; bus.chk_y = 8'd4;
        #1;
        check_eq("edge_cgnt", bus.chk_gnt, 1);
        check_eq("edge_memstep", bus.mem_step, 5);
        step_clk();
        check_eq("edge_cvalid", bus.chk_valid, 1);
        check_eq("edge_cdata", bus.chk_data, rom_word(4'd5, 8'd3, 8'd4));
        check_eq("edge_rdstep", bus.rd_step, 5);
        check_eq("edge_step", step, 6);
        check_eq("edge_pulse", step_pulse, 1);

        // Both requesting: checker wins every 8th cycle
        for (int i = 0; i < 16; i++) begin
            bus.disp_req = 1'b1; bus.disp_x = 8'(i); bus.disp_y = 8'(i + 1);
            bus.chk_req  = 1'b1; bus.chk_x  = 8'(20 + i); bus.chk_y = 8'(40 + i);
            #1;
            check_eq("starve_dgnt", bus.disp_gnt, (i % 8 != 7));
            check_eq("starve_cgnt", bus.chk_gnt, (i % 8 == 7));
            step_clk();
            if (i % 8 == 7) begin
                check_eq("starve_cvalid", bus.chk_valid, 1);
                check_eq("starve_dvalid", bus.disp_valid, 0);
                check_eq("starve_cdata", bus.chk_data, rom_word(4'(6 + i / 8), 8'(20 + i), 8'(40 + i)));
                check_eq("starve_rdstep", bus.rd_step, 6 + i / 8);
            end else begin
                check_eq("starve_dvalid", bus.disp_valid, 1);
                check_eq("starve_cvalid", bus.chk_valid, 0);
            end
        end
        bus.disp_req = 1'b0; bus.chk_req = 1'b0;
        check_eq("after_starve_step", step, 8);
        wait_pulse(n);
        check_eq("step9", step, 9);

        // Asynchronous reset mid-read
        bus.disp_req = 1'b1; bus.disp_x = 8'd7; bus.disp_y = 8'd2;
        #1;
        check_eq("rst_mid_dgnt", bus.disp_gnt, 1);
        check_eq("rst_mid_memstep", bus.mem_step, 9);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_step", step, 0);
        check_eq("arst_running", running, 0);
        check_eq("arst_rdstep", bus.rd_step, 0);
        check_eq("arst_ddata", bus.disp_data, 0);
        check_eq("arst_cdata", bus.chk_data, 0);
        step_clk();
        check_eq("arst_dvalid", bus.disp_valid, 0);
        bus.disp_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step_clk();
        check_eq("post_rst_running", running, 0);

        start = 1'b1;
        step_clk();
        start = 1'b0;
        check_eq("restart_running", running, 1);
        check_eq("restart_step", step, 0);
        for (int s = 0; s < 16; s++) begin
            wait_pulse(n);
            check_eq("full_period", n, 8);
        end
        check_eq("end_step", step, 0);
`ifdef EXPECT_LOOP_EN
        check_eq("loop_running", running, 1);
        check_eq("loop_done", done, 0);
        wait_pulse(n);
        check_eq("loop_step1", step, 1);
        check_eq("loop_done_still", done, 0);
`else
        check_eq("end_done", done, 1);
        check_eq("end_running", running, 0);
        repeat (10) step_clk();
        check_eq("done_hold", done, 1);
        check_eq("done_step_hold", step, 0);
        check_eq("done_no_pulse", step_pulse, 0);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        check_eq("done_restart_running", running, 1);
        check_eq("done_restart_done", done, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
